// File: rtl/bus_response_mux_pkg.sv
// Shared constants for the peripheral-bus response path: slave count, chip-select
// bit positions, the error data word and the response FSM state encodings.
package bus_response_mux_pkg;

    localparam int          DEF_N_SLAVES = 7;
    localparam int          DEF_TIMEOUT  = 255;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

    // Chip-select bit positions as produced by the address decoder
    localparam int CS_RAM        = 0;
    localparam int CS_MULT       = 1;
    localparam int CS_DIV        = 2;
    localparam int CS_BIN_TO_BCD = 3;
    localparam int CS_GPIO       = 4;
    localparam int CS_UART       = 5;
    localparam int CS_DPRAM      = 6;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_WR_WAIT = 2'd2;

endpackage

// File: rtl/bus_response_mux_rdata_onehot_mux.sv
// AND-OR read-data selector driven by the latched chip-select, plus a flag telling
// whether that chip-select names exactly one slave.
module rdata_onehot_mux #(
    parameter int N_SLAVES = 7
) (
    input  logic [N_SLAVES-1:0]    cs_q,
    input  logic [32*N_SLAVES-1:0] slave_rdata,
    output logic [31:0]            sel_rdata,
    output logic                   onehot_ok
);

    logic [31:0] masked [N_SLAVES];

    genvar gi;
    generate
        for (gi = 0; gi < N_SLAVES; gi++) begin : g_mask
            assign masked[gi] = slave_rdata[32*gi +: 32] & {32{cs_q[gi]}};
        end
    endgenerate

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            sel_rdata = sel_rdata | masked[i];
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing
    assign onehot_ok = (cs_q != '0) && ((cs_q & (cs_q - N_SLAVES'(1))) == '0);

endmodule

// File: rtl/bus_response_mux.sv
// Response side of the peripheral bus: latches the chip-select on a CPU strobe, waits
// for the selected slave, returns read data and flags timeouts and bad selects.
module bus_response_mux
    import bus_response_mux_pkg::*;
#(
    parameter int          N_SLAVES = DEF_N_SLAVES,
    parameter int          TIMEOUT  = DEF_TIMEOUT,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   mem_rstrb,
    input  logic [3:0]             mem_wstrb,
    input  logic [N_SLAVES-1:0]    cs,
    input  logic [32*N_SLAVES-1:0] slave_rdata,
    input  logic [N_SLAVES-1:0]    slave_ready,
    input  logic                   err_clr,
    output logic [31:0]            mem_rdata,
    output logic                   mem_rbusy,
    output logic                   mem_wbusy,
    output logic                   bus_err
);

    localparam int             CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TIMEOUT_C = CW'(TIMEOUT);

    logic [1:0]          state_reg, state_next;
    logic [N_SLAVES-1:0] cs_reg, cs_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [31:0]         rdata_reg, rdata_next;
    logic                err_reg, err_next;
    logic                err_set;

    logic [31:0] sel_rdata;
    logic        onehot_ok;
    logic        ready_hit;
    logic        in_read;

    rdata_onehot_mux #(
        .N_SLAVES (N_SLAVES)
    ) u_sel (
        .cs_q        (cs_reg),
        .slave_rdata (slave_rdata),
        .sel_rdata   (sel_rdata),
        .onehot_ok   (onehot_ok)
    );

    assign ready_hit = |(slave_ready & cs_reg);
    assign in_read   = (state_reg == ST_RD_WAIT);

    always_comb begin
        state_next = state_reg;
        cs_next    = cs_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        err_set    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A write always wins; a simultaneous read is dropped and flagged
                if (|mem_wstrb) begin
                    cs_next    = cs;
                    cnt_next   = '0;
                    state_next = ST_WR_WAIT;
                    err_set    = mem_rstrb;
                end else if (mem_rstrb) begin
                    cs_next    = cs;
                    cnt_next   = '0;
                    state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (!onehot_ok) begin
                    state_next = ST_IDLE;
                    err_set    = 1'b1;
                    if (in_read) rdata_next = ERR_DATA;
                end else if (ready_hit) begin
                    state_next = ST_IDLE;
                    if (in_read) rdata_next = sel_rdata;
                end else if (cnt_reg == TIMEOUT_C) begin
                    state_next = ST_IDLE;
                    err_set    = 1'b1;
                    if (in_read) rdata_next = ERR_DATA;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A new error in the same cycle as err_clr keeps the flag set
    assign err_next = err_set | (err_reg & ~err_clr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            cs_reg    <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cs_reg    <= cs_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    assign mem_rdata = rdata_reg;
    assign mem_rbusy = (state_reg == ST_RD_WAIT);
    assign mem_wbusy = (state_reg == ST_WR_WAIT);
    assign bus_err   = err_reg;

endmodule

// File: tb/tb_bus_response_mux.sv
// Directed bench for bus_response_mux: stimulus pushes expected completions into a
// queue, a negedge monitor pops and compares each time a busy period ends.
module tb_bus_response_mux;

    localparam int NS = 7;

    logic            clk;
    logic            resetn;
    logic            mem_rstrb;
    logic [3:0]      mem_wstrb;
    logic [NS-1:0]   cs;
    logic [32*NS-1:0] slave_rdata;
    logic [NS-1:0]   slave_ready;
    logic            err_clr;
    logic [31:0]     mem_rdata;
    logic            mem_rbusy;
    logic            mem_wbusy;
    logic            bus_err;

    typedef struct {
        bit          rd;
        logic [31:0] rdata;
        bit          err;
        int          busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bus_response_mux #(
        .N_SLAVES (NS),
        .TIMEOUT  (4),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_rstrb   (mem_rstrb),
        .mem_wstrb   (mem_wstrb),
        .cs          (cs),
        .slave_rdata (slave_rdata),
        .slave_ready (slave_ready),
        .err_clr     (err_clr),
        .mem_rdata   (mem_rdata),
        .mem_rbusy   (mem_rbusy),
        .mem_wbusy   (mem_wbusy),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: measures each busy period and checks it against the next expectation
    int  run_len   = 0;
    bit  prev_busy = 0;
    bit  run_rd    = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            run_len   = 0;
            prev_busy = 0;
        end else begin
            if (mem_rbusy || mem_wbusy) begin
                run_len++;
                run_rd = mem_rbusy;
                prev_busy = 1;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: completion with no expectation, rdata=0x%08h", mem_rdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_kind",  {31'd0, run_rd},  {31'd0, e.rd});
                    chk("sb_rdata", mem_rdata,        e.rdata);
                    chk("sb_err",   {31'd0, bus_err}, {31'd0, e.err});
                    chk("sb_busy",  run_len,          e.busy);
                    $display("txn %s rdata=0x%08h err=%0d busy=%0d", e.rd ? "RD" : "WR",
                             mem_rdata, bus_err, run_len);
                end
                run_len   = 0;
                prev_busy = 0;
            end
        end
    end

    // One bus access; rdy_dly is the cycle after the strobe in which ready rises (0 = never)
    task automatic access(input bit rs, input logic [3:0] ws, input logic [NS-1:0] c,
                          input int rdy_dly, input int rdy_idx, input bit hold_clr,
                          input bit extra, input logic [31:0] e_rdata, input bit e_err,
                          input int e_busy);
        exp_t e;
        bit   done;
        e.rd = (ws == 4'b0000);
        e.rdata = e_rdata;
        e.err = e_err;
        e.busy = e_busy;
        exp_q.push_back(e);
        @(posedge clk); #1;
        mem_rstrb = rs;
        mem_wstrb = ws;
        cs        = c;
        err_clr   = hold_clr;
        done      = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge clk); #1;
            mem_rstrb = 1'b0;
            mem_wstrb = 4'b0000;
            if (extra && k == 1) begin
                mem_rstrb = 1'b1;
                cs        = 7'b0000010;
            end
            if (extra && k == 2) mem_wstrb = 4'b1111;
            if (k == rdy_dly) slave_ready[rdy_idx] = 1'b1;
            if (k >= 2 && !mem_rbusy && !mem_wbusy) done = 1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL access_timeout: busy still high after 40 cycles, rbusy=%0d wbusy=%0d",
                     mem_rbusy, mem_wbusy);
        end
        slave_ready = '0;
        err_clr     = 1'b0;
        cs          = '0;
    endtask

    task automatic clear_err();
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] sd [NS];
        sd[0] = 32'h1234_5678; sd[1] = 32'h1111_1111; sd[2] = 32'h2222_2222;
        sd[3] = 32'h3333_3333; sd[4] = 32'h0000_00A5; sd[5] = 32'h5555_5555;
        sd[6] = 32'h6666_6666;
        for (int i = 0; i < NS; i++) slave_rdata[32*i +: 32] = sd[i];

        resetn      = 1'b0;
        mem_rstrb   = 1'b0;
        mem_wstrb   = 4'b0000;
        cs          = '0;
        slave_ready = '0;
        err_clr     = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_rbusy", {31'd0, mem_rbusy}, 32'd0);
        chk("rst_wbusy", {31'd0, mem_wbusy}, 32'd0);
        chk("rst_err",   {31'd0, bus_err},   32'd0);

        // gpio read, ready one cycle after the strobe
        access(1, 4'b0000, 7'b0010000, 1, 4, 0, 0, 32'h0000_00A5, 0, 1);
        // uart write, ready after 3 cycles; read data untouched
        access(0, 4'b0001, 7'b0100000, 3, 5, 0, 0, 32'h0000_00A5, 0, 3);
        // RAM read that never completes: timeout after TIMEOUT+1 busy cycles
        access(1, 4'b0000, 7'b0000001, 0, 0, 0, 0, 32'hDEAD_BEEF, 1, 5);
        repeat (2) @(posedge clk);
        #1 chk("err_sticky", {31'd0, bus_err}, 32'd1);
        clear_err();
        chk("err_cleared", {31'd0, bus_err}, 32'd0);

        access(1, 4'b0000, 7'b0010000, 1, 4, 0, 0, 32'h0000_00A5, 0, 1);
        // no chip-select while err_clr is held: the new error wins
        access(1, 4'b0000, 7'b0000000, 0, 0, 1, 0, 32'hDEAD_BEEF, 1, 1);
        chk("err_set_wins", {31'd0, bus_err}, 32'd1);
        clear_err();

        access(1, 4'b0000, 7'b0010000, 1, 4, 0, 0, 32'h0000_00A5, 0, 1);
        // two chip-selects with a ready slave still counts as invalid
        access(1, 4'b0000, 7'b0000011, 1, 0, 0, 0, 32'hDEAD_BEEF, 1, 1);
        clear_err();

        // read and write strobes together: write runs, error raised
        access(1, 4'b1111, 7'b0000100, 2, 2, 0, 0, 32'hDEAD_BEEF, 1, 2);
        clear_err();
        chk("err_cleared2", {31'd0, bus_err}, 32'd0);

        // dpRAM read with stray strobes during the wait
        access(1, 4'b0000, 7'b1000000, 3, 6, 0, 1, 32'h6666_6666, 0, 3);
        access(1, 4'b0000, 7'b0000000, 0, 0, 0, 0, 32'hDEAD_BEEF, 1, 1);

        // asynchronous reset in the middle of a read
        @(posedge clk); #1;
        mem_rstrb = 1'b1;
        cs        = 7'b0001000;
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        cs        = '0;
        chk("pre_rst_rbusy", {31'd0, mem_rbusy}, 32'd1);
        chk("pre_rst_err",   {31'd0, bus_err},   32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_rbusy", {31'd0, mem_rbusy}, 32'd0);
        chk("async_rst_rdata", mem_rdata, 32'h0);
        chk("async_rst_err",   {31'd0, bus_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_rbusy", {31'd0, mem_rbusy}, 32'd0);

        access(1, 4'b0000, 7'b0010000, 1, 4, 0, 0, 32'h0000_00A5, 0, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
